// File: rtl/sreg_pkg.sv
// Shared encodings for the universal shift register:
// operation modes, burst FSM states and the burst-mode test.
package sreg_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHL  = 3'b001;
  localparam logic [2:0] MODE_SHR  = 3'b010;
  localparam logic [2:0] MODE_ROL  = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_LOAD = 3'b101;
  localparam logic [2:0] MODE_CLR  = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Only shifts and rotates may be repeated by a burst.
  function automatic logic is_burst_mode(input logic [2:0] m);
    return (m == MODE_SHL) || (m == MODE_SHR) ||
           (m == MODE_ROL) || (m == MODE_ROR);
  endfunction

endpackage

// File: rtl/sreg_next.sv
// Next-state datapath of the shift register: one operation
// applied to q, shared by single-cycle and burst paths.
module sreg_next
  import sreg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic [2:0]       op,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] nxt
);

  always_comb begin
    nxt = q;
    unique case (op)
      MODE_SHL:  nxt = {q[WIDTH-2:0], sin_r};
      MODE_SHR:  nxt = {sin_l, q[WIDTH-1:1]};
      MODE_ROL:  nxt = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_ROR:  nxt = {q[0], q[WIDTH-1:1]};
      MODE_LOAD: nxt = d;
      MODE_CLR:  nxt = '0;
      default:   nxt = q;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with single-cycle operations and
// an automatic N-step shift/rotate burst.
module univ_shift_reg
  import sreg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic             start,
  input  logic [CNT_W-1:0] shift_n,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] count;
  logic [2:0]       bmode;
  logic [2:0]       op;
  logic [WIDTH-1:0] q_nxt;
  logic             burst_go;

  assign burst_go = (state == S_IDLE) && start &&
                    is_burst_mode(mode);

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (burst_go)
          state_nxt = (shift_n == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (count == CNT_W'(1)) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_RUN);
    done = (state == S_DONE);
  end

  // The start edge itself leaves q untouched.
  always_comb begin
    op = MODE_HOLD;
    unique case (state)
      S_IDLE:  if (!burst_go && en) op = mode;
      S_RUN:   op = bmode;
      default: op = MODE_HOLD;
    endcase
  end

  sreg_next #(.WIDTH(WIDTH)) u_next (
    .q     (q),
    .op    (op),
    .sin_l (sin_l),
    .sin_r (sin_r),
    .d     (d),
    .nxt   (q_nxt)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      q     <= '0;
      count <= '0;
      bmode <= MODE_HOLD;
    end else begin
      q <= q_nxt;
      if (burst_go) begin
        count <= shift_n;
        bmode <= mode;
      end else if (state == S_RUN) begin
        count <= count - 1'b1;
      end
    end
  end

  assign sout_l = q[WIDTH-1];
  assign sout_r = q[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed self-checking bench for univ_shift_reg (WIDTH=8)
// using immediate assertions at every comparison point.
module tb_univ_shift_reg;

  import sreg_pkg::*;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic [2:0]    mode;
  logic [W-1:0]  d;
  logic          sin_l;
  logic          sin_r;
  logic          start;
  logic [CW-1:0] shift_n;
  logic [W-1:0]  q;
  logic          sout_l;
  logic          sout_r;
  logic          busy;
  logic          done;

  int n_chk  = 0;
  int n_fail = 0;

  univ_shift_reg #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .mode    (mode),
    .d       (d),
    .sin_l   (sin_l),
    .sin_r   (sin_r),
    .start   (start),
    .shift_n (shift_n),
    .q       (q),
    .sout_l  (sout_l),
    .sout_r  (sout_r),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic load(input logic [W-1:0] v);
    en = 1'b1; mode = MODE_LOAD; d = v;
    step();
    en = 1'b0; mode = MODE_HOLD;
  endtask

  initial begin
    int bcnt;
    int k;
    reset = 1'b0; en = 1'b0; mode = MODE_HOLD; d = '0;
    sin_l = 1'b0; sin_r = 1'b0; start = 1'b0; shift_n = '0;
    step();
    step();
    chk("rst_q", 32'(q), 32'h00);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    reset = 1'b1;

    // 1: reset needs a clock edge
    load(8'hA5);
    chk("load_a5", 32'(q), 32'hA5);
    reset = 1'b0;
    #6;
    chk("rst_noedge", 32'(q), 32'hA5);
    @(posedge clk); #1;
    chk("rst_edge_q", 32'(q), 32'h00);
    chk("rst_edge_busy", 32'(busy), 32'h0);
    chk("rst_edge_done", 32'(done), 32'h0);
    reset = 1'b1;

    // 2: shifts and hold
    load(8'hA5);
    en = 1'b1; mode = MODE_SHL; sin_r = 1'b1;
    step();
    chk("shl", 32'(q), 32'h4B);
    mode = MODE_SHR; sin_l = 1'b0; sin_r = 1'b0;
    step();
    chk("shr", 32'(q), 32'h25);
    en = 1'b0; mode = MODE_SHL;
    step();
    chk("en0_hold", 32'(q), 32'h25);
    mode = 3'b111; en = 1'b1;
    step();
    chk("rsvd_hold", 32'(q), 32'h25);
    en = 1'b0;

    // 3: rotates and clear
    load(8'h81);
    chk("sout_l", 32'(sout_l), 32'h1);
    chk("sout_r", 32'(sout_r), 32'h1);
    en = 1'b1; mode = MODE_ROL;
    step();
    chk("rol", 32'(q), 32'h03);
    load(8'h81);
    en = 1'b1; mode = MODE_ROR;
    step();
    chk("ror", 32'(q), 32'hC0);
    mode = MODE_CLR;
    step();
    chk("clr", 32'(q), 32'h00);
    en = 1'b0;

    // 4: burst rol x3
    load(8'h01);
    start = 1'b1; mode = MODE_ROL; shift_n = 4'd3;
    step();
    start = 1'b0; mode = MODE_HOLD;
    chk("b4_start_q", 32'(q), 32'h01);
    chk("b4_busy0", 32'(busy), 32'h1);
    step();
    chk("b4_q1", 32'(q), 32'h02);
    chk("b4_busy1", 32'(busy), 32'h1);
    step();
    chk("b4_q2", 32'(q), 32'h04);
    chk("b4_busy2", 32'(busy), 32'h1);
    step();
    chk("b4_q3", 32'(q), 32'h08);
    chk("b4_busy3", 32'(busy), 32'h0);
    chk("b4_done", 32'(done), 32'h1);
    step();
    chk("b4_done_off", 32'(done), 32'h0);
    chk("b4_q_final", 32'(q), 32'h08);

    // 5: inputs ignored during burst and done
    start = 1'b1; mode = MODE_SHL; shift_n = 4'd2; sin_r = 1'b0;
    step();
    mode = MODE_LOAD; en = 1'b1; d = 8'hFF;
    chk("b5_q0", 32'(q), 32'h08);
    step();
    chk("b5_q1", 32'(q), 32'h10);
    chk("b5_busy", 32'(busy), 32'h1);
    step();
    chk("b5_q2", 32'(q), 32'h20);
    chk("b5_done", 32'(done), 32'h1);
    step();
    chk("b5_done_hold", 32'(q), 32'h20);
    chk("b5_done_off", 32'(done), 32'h0);
    step();
    chk("start_load", 32'(q), 32'hFF);
    chk("start_load_busy", 32'(busy), 32'h0);
    en = 1'b0; mode = MODE_ROR; shift_n = 4'd0;
    step();
    start = 1'b0;
    chk("zero_busy", 32'(busy), 32'h0);
    chk("zero_done", 32'(done), 32'h1);
    chk("zero_q", 32'(q), 32'hFF);
    step();
    chk("zero_done_off", 32'(done), 32'h0);

    // shift_n beyond WIDTH is not clamped
    load(8'h01);
    start = 1'b1; mode = MODE_ROL; shift_n = 4'd9;
    step();
    start = 1'b0; mode = MODE_HOLD;
    bcnt = 0;
    k = 0;
    while (!done && k < 20) begin
      if (busy) bcnt++;
      step();
      k++;
    end
    chk("long_timeout", 32'(done), 32'h1);
    chk("long_busy_cycles", 32'(bcnt), 32'd9);
    chk("long_q", 32'(q), 32'h02);
    step();

    // 6: reset mid-burst
    load(8'h01);
    start = 1'b1; mode = MODE_SHL; shift_n = 4'd5; sin_r = 1'b0;
    step();
    start = 1'b0;
    step();
    chk("b6_q1", 32'(q), 32'h02);
    reset = 1'b0;
    step();
    chk("b6_rst_q", 32'(q), 32'h00);
    chk("b6_rst_busy", 32'(busy), 32'h0);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("b6_no_done", 32'(done), 32'h0);
      step();
    end
    chk("b6_idle_q", 32'(q), 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
